// File: rtl/fc_obuf.sv
// Output buffer for a fully-connected CIM tile: shift-adds LSB-first bit-plane partial sums,
// requantizes (shift + saturate) and drains NUM_CHANNELS elements per valid/ready beat.
module fc_obuf #(
    parameter int DATA_SIZE    = 8,
    parameter int XBAR_SIZE    = 128,
    parameter int NUM_ELEMS    = 16,
    parameter int PSUM_WIDTH   = DATA_SIZE + $clog2(XBAR_SIZE),
    parameter int ACC_WIDTH    = PSUM_WIDTH + DATA_SIZE,
    parameter int NUM_CHANNELS = 2,
    parameter int OUT_SHIFT    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_psum_valid,
    input  logic [NUM_ELEMS-1:0][PSUM_WIDTH-1:0]   i_psum,
    output logic                                   o_busy,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [NUM_CHANNELS-1:0][DATA_SIZE-1:0] o_data,
    output logic                                   o_done,
    output logic                                   o_overrun
);

    localparam int NUM_BEATS = (NUM_ELEMS + NUM_CHANNELS - 1) / NUM_CHANNELS;
    localparam int BC_W      = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int BT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int EL_W      = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** DATA_SIZE) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc [NUM_ELEMS];
    logic [BC_W-1:0]      bit_cnt;
    logic [BT_W-1:0]      beat_cnt;
    logic                 done_nxt;
    logic                 overrun_nxt;
    logic                 last_bit;
    logic                 last_beat;

    assign last_bit  = (bit_cnt == BC_W'(DATA_SIZE - 1));
    assign last_beat = (beat_cnt == BT_W'(NUM_BEATS - 1));

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        overrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (i_psum_valid)
                    state_nxt = (DATA_SIZE == 1) ? DRAIN : ACCUM;
            end
            ACCUM: begin
                if (i_psum_valid && last_bit)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Planes arriving here belong to nobody; flag them, never fold them in.
                overrun_nxt = i_psum_valid;
                if (i_ready && last_beat) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            beat_cnt  <= '0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_done    <= done_nxt;
            o_overrun <= overrun_nxt;
            case (state)
                IDLE: begin
                    if (i_psum_valid) begin
                        bit_cnt  <= BC_W'(1);
                        beat_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (i_psum_valid) begin
                        if (last_bit)
                            beat_cnt <= '0;
                        else
                            bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                DRAIN: begin
                    if (i_ready && !last_beat)
                        beat_cnt <= beat_cnt + BT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_ELEMS; e++)
                acc[e] <= '0;
        end else if (i_psum_valid) begin
            for (int e = 0; e < NUM_ELEMS; e++) begin
                // Plane 0 overwrites so a new pass never inherits the previous result.
                if (state == IDLE)
                    acc[e] <= ACC_WIDTH'(i_psum[e]);
                else if (state == ACCUM)
                    acc[e] <= acc[e] + (ACC_WIDTH'(i_psum[e]) << bit_cnt);
            end
        end
    end

    assign o_valid = (state == DRAIN);
    assign o_busy  = (state != IDLE);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [31:0]          elem;
        logic [ACC_WIDTH-1:0] sel;
        logic [ACC_WIDTH-1:0] shifted;

        assign elem    = 32'(beat_cnt) * 32'(NUM_CHANNELS) + 32'(c);
        assign sel     = (elem < 32'(NUM_ELEMS)) ? acc[elem[EL_W-1:0]] : '0;
        assign shifted = sel >> OUT_SHIFT;
        assign o_data[c] = (state != DRAIN)     ? '0 :
                           (shifted > SAT_MAX)  ? {DATA_SIZE{1'b1}} :
                                                  shifted[DATA_SIZE-1:0];
    end

endmodule

// File: tb/tb_fc_obuf.sv
// Directed bench: three fc_obuf instances (OUT_SHIFT 0, 8, 1) share stimulus; each drained
// beat is compared against per-element expected values written by the individual tests.
module tb_fc_obuf;

    localparam int DS = 8;
    localparam int NE = 16;
    localparam int PW = 15;
    localparam int NC = 2;
    localparam int NB = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n      = 1'b0;
    logic                   psum_valid = 1'b0;
    logic                   ready      = 1'b0;
    logic [NE-1:0][PW-1:0]  psum       = '0;

    logic                   busy    [NI];
    logic                   valid   [NI];
    logic                   done    [NI];
    logic                   overrun [NI];
    logic [NC-1:0][DS-1:0]  data    [NI];

    int vectors     = 0;
    int miscompares = 0;

    logic [PW-1:0] tab     [DS][NE];
    int            exp_val [NI][NE];

    fc_obuf #(.OUT_SHIFT(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .i_psum_valid(psum_valid), .i_psum(psum),
        .o_busy(busy[0]), .o_valid(valid[0]), .i_ready(ready), .o_data(data[0]),
        .o_done(done[0]), .o_overrun(overrun[0]));

    fc_obuf #(.OUT_SHIFT(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .i_psum_valid(psum_valid), .i_psum(psum),
        .o_busy(busy[1]), .o_valid(valid[1]), .i_ready(ready), .o_data(data[1]),
        .o_done(done[1]), .o_overrun(overrun[1]));

    fc_obuf #(.OUT_SHIFT(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .i_psum_valid(psum_valid), .i_psum(psum),
        .o_busy(busy[2]), .o_valid(valid[2]), .i_ready(ready), .o_data(data[2]),
        .o_done(done[2]), .o_overrun(overrun[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uniform(input int v);
        for (int p = 0; p < DS; p++)
            for (int e = 0; e < NE; e++)
                tab[p][e] = PW'(v);
    endtask

    task automatic set_exp(input int e0, input int e8, input int e1);
        for (int e = 0; e < NE; e++) begin
            exp_val[0][e] = e0;
            exp_val[1][e] = e8;
            exp_val[2][e] = e1;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (busy[k] !== 1'b0 || valid[k] !== 1'b0 || data[k] !== '0) begin
                miscompares++;
                $display("FAIL %s inst%0d: busy=%b valid=%b data=%h, required 0 0 0",
                         name, k, busy[k], valid[k], data[k]);
            end
        end
    endtask

    // Full pass of DS planes from tab, with 'gap' idle cycles between planes.
    task automatic send_pass(input int gap);
        for (int p = 0; p < DS; p++) begin
            psum_valid = 1'b1;
            for (int e = 0; e < NE; e++)
                psum[e] = tab[p][e];
            tick();
            psum_valid = 1'b0;
            psum       = '0;
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if (valid[k] !== (p == DS - 1)) begin
                    miscompares++;
                    $display("FAIL latency inst%0d plane%0d: valid=%b, required %b",
                             k, p, valid[k], (p == DS - 1));
                end
            end
            if (p < DS - 1)
                repeat (gap) tick();
        end
    endtask

    // Drain with a repeating ready pattern (bit i = ready in cycle i mod plen).
    task automatic drain(input logic [15:0] pat, input int plen);
        int hs  = 0;
        int cyc = 0;
        while (hs < NB && cyc < 200) begin
            ready = pat[cyc % plen];
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if (valid[k] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL drain_valid inst%0d beat%0d: valid=%b, required 1", k, hs, valid[k]);
                end
                for (int c = 0; c < NC; c++) begin
                    vectors++;
                    if (data[k][c] !== DS'(exp_val[k][hs*NC+c])) begin
                        miscompares++;
                        $display("FAIL data inst%0d beat%0d ch%0d: got %0d, required %0d",
                                 k, hs, c, data[k][c], exp_val[k][hs*NC+c]);
                    end
                end
            end
            if (ready) hs++;
            tick();
            cyc++;
        end
        ready = 1'b0;
        vectors++;
        if (hs != NB) begin
            miscompares++;
            $display("FAIL drain_timeout: handshakes=%0d, required %0d", hs, NB);
        end
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (done[k] !== 1'b1 || valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL done inst%0d: done=%b valid=%b busy=%b, required 1 0 0",
                         k, done[k], valid[k], busy[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (done[k] !== 1'b0 || overrun[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_pulses inst%0d: done=%b overrun=%b, required 0 0",
                         k, done[k], overrun[k]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_ones();
        set_uniform(1);
        set_exp(255, 0, 127);
        send_pass(0);
        drain(16'hFFFF, 1);
        tick();
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (done[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL done_pulse_width inst%0d: done=%b, required 0", k, done[k]);
            end
        end
    endtask

    task automatic test_single_elem();
        set_uniform(0);
        tab[3][3] = 15'd5;
        set_exp(0, 0, 0);
        exp_val[0][3] = 40;
        exp_val[2][3] = 20;
        send_pass(0);
        drain(16'hFFFF, 1);
    endtask

    task automatic test_saturate_stall();
        set_uniform(100);
        set_exp(255, 99, 255);
        send_pass(0);
        drain(16'b011001, 6);
    endtask

    task automatic test_gaps_overrun();
        for (int p = 0; p < DS; p++)
            for (int e = 0; e < NE; e++)
                tab[p][e] = PW'(e * 10 + 1);
        for (int e = 0; e < NE; e++) begin
            exp_val[0][e] = 255;
            exp_val[1][e] = ((255 * (e * 10 + 1)) >> 8) > 255 ? 255 : ((255 * (e * 10 + 1)) >> 8);
            exp_val[2][e] = ((255 * (e * 10 + 1)) >> 1) > 255 ? 255 : ((255 * (e * 10 + 1)) >> 1);
        end
        send_pass(2);
        psum_valid = 1'b1;
        psum       = {NE{15'h7FFF}};
        tick();
        psum_valid = 1'b0;
        psum       = '0;
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (overrun[k] !== 1'b1 || valid[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL overrun_pulse inst%0d: overrun=%b valid=%b, required 1 1",
                         k, overrun[k], valid[k]);
            end
        end
        tick();
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (overrun[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL overrun_clear inst%0d: overrun=%b, required 0", k, overrun[k]);
            end
        end
        drain(16'b011001, 6);
    endtask

    task automatic test_back_to_back();
        set_uniform(1);
        set_exp(255, 0, 127);
        send_pass(0);
        drain(16'hFFFF, 1);
        // Next pass starts in the very cycle o_done is high.
        set_uniform(0);
        tab[3][3] = 15'd5;
        send_pass(0);
        set_exp(0, 0, 0);
        exp_val[0][3] = 40;
        exp_val[2][3] = 20;
        drain(16'hFFFF, 1);
    endtask

    task automatic test_reset_mid();
        set_uniform(7);
        for (int p = 0; p < 4; p++) begin
            psum_valid = 1'b1;
            for (int e = 0; e < NE; e++)
                psum[e] = tab[p][e];
            tick();
        end
        psum_valid = 1'b0;
        psum       = '0;
        rst_n      = 1'b0;
        #2;
        check_idle_outputs("reset_mid_accum");
        tick();
        rst_n = 1'b1;
        tick();
        set_uniform(2);
        set_exp(255, 1, 255);
        send_pass(0);
        drain(16'hFFFF, 1);

        set_uniform(9);
        send_pass(0);
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        rst_n = 1'b0;
        #2;
        check_idle_outputs("reset_mid_drain");
        tick();
        rst_n = 1'b1;
        tick();
        set_uniform(1);
        set_exp(255, 0, 127);
        send_pass(0);
        drain(16'hFFFF, 1);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_elem();
        test_saturate_stall();
        test_gaps_overrun();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
